// File: rtl/alu_mdu.sv
// alu_mdu: RV32/RV64 execute unit. Base ALU ops plus the M extension (multiply, divide, remainder)
// behind a valid/ready handshake; one operation in flight, registered result and flags.
module alu_mdu #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALU_out,
  output logic            zero,
  output logic            less,
  output logic            less_unsigned
);

  localparam int SHW  = $clog2(XLEN);
  localparam int CMAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0]   MUL_LAST  = (MUL_LAT > 1) ? CW'(MUL_LAT - 2) : '0;
  localparam logic [CW-1:0]   DIV_LAST  = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam bit              MUL_MULTI = (MUL_LAT > 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_n;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] a_q, b_q;
  logic [1:0]      mf_q;
  logic [XLEN-1:0] rem_q, quot_q, dvs_q;
  logic            neg_q, neg_r, rem_sel;

  logic            accept;
  logic            is_mul, is_div, div_sgn, div_zero, div_ovf;
  logic [XLEN-1:0] acc_res;
  logic [1:0]      mul_f;
  logic [XLEN-1:0] mul_a, mul_b, mul_out;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] rem_n, quot_n, q_fin, r_fin, div_fin;
  logic            res_we;
  logic [XLEN-1:0] res_n;

  function automatic logic [XLEN-1:0] base_alu(input logic [3:0] code,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] r;
    sh = b[SHW-1:0];
    case (code)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0000: r = a & b;
      4'b0111: r = a | b;
      4'b0100: r = a ^ b;
      4'b1010: r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'b0011: r = {{(XLEN-1){1'b0}}, a < b};
      4'b0001: r = a << sh;
      4'b0101: r = a >> sh;
      4'b1101: r = $signed(a) >>> sh;
      4'b1000: r = b;
      default: r = {(XLEN/32){32'hdeadbeef}};
    endcase
    return r;
  endfunction

  // f: 00 low half, 01 s*s high, 10 s*u high, 11 u*u high
  function automatic logic [XLEN-1:0] mul_res(input logic [1:0] f,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic              sa, sb;
    logic [2*XLEN-1:0] ax, bx, p;
    sa = a[XLEN-1] & ((f == 2'b01) | (f == 2'b10));
    sb = b[XLEN-1] & (f == 2'b01);
    ax = {{XLEN{sa}}, a};
    bx = {{XLEN{sb}}, b};
    p  = ax * bx;
    return (f == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic sgn, input logic [XLEN-1:0] x);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction

  assign in_ready  = ~flush & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == S_DONE);

  // One multiplier serves both the single-cycle path (live inputs) and the
  // multi-cycle path (latched operands while in S_MUL).
  always_comb begin
    mul_f   = (state == S_MUL) ? mf_q : op[1:0];
    mul_a   = (state == S_MUL) ? a_q  : data1;
    mul_b   = (state == S_MUL) ? b_q  : data2;
    mul_out = mul_res(mul_f, mul_a, mul_b);
  end

  always_comb begin
    is_mul   = op[4] & ~op[2];
    is_div   = op[4] & op[2];
    div_sgn  = ~op[0];
    div_zero = (data2 == '0);
    div_ovf  = div_sgn & (data1 == MOST_NEG) & (data2 == '1);
    acc_res  = base_alu(op[3:0], data1, data2);
    if (is_mul) begin
      acc_res = mul_out;
    end else if (is_div) begin
      if (div_zero) acc_res = op[1] ? data1 : '1;
      else          acc_res = op[1] ? '0 : data1;
    end
  end

  // Restoring divide step: the dividend shifts out of quot_q while quotient bits shift in.
  always_comb begin
    rem_sh  = {rem_q, quot_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    rem_n   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quot_n  = {quot_q[XLEN-2:0], ~diff[XLEN]};
    q_fin   = neg_q ? -quot_n : quot_n;
    r_fin   = neg_r ? -rem_n : rem_n;
    div_fin = rem_sel ? r_fin : q_fin;
  end

  always_comb begin
    state_n = state;
    res_we  = 1'b0;
    res_n   = acc_res;
    if (flush) begin
      state_n = S_IDLE;
    end else if (accept) begin
      if (is_mul && MUL_MULTI) begin
        state_n = S_MUL;
      end else if (is_div && !div_zero && !div_ovf) begin
        state_n = S_DIV;
      end else begin
        state_n = S_DONE;
        res_we  = 1'b1;
      end
    end else begin
      case (state)
        S_MUL: if (cnt == MUL_LAST) begin
          state_n = S_DONE;
          res_we  = 1'b1;
          res_n   = mul_out;
        end
        S_DIV: if (cnt == DIV_LAST) begin
          state_n = S_DONE;
          res_we  = 1'b1;
          res_n   = div_fin;
        end
        S_DONE: if (out_ready) state_n = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_out       <= '0;
      zero          <= 1'b0;
      less          <= 1'b0;
      less_unsigned <= 1'b0;
      cnt           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      mf_q          <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      dvs_q         <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      rem_sel       <= 1'b0;
    end else begin
      if (res_we) begin
        ALU_out <= res_n;
        zero    <= (res_n == '0);
      end
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        cnt           <= '0;
        less          <= $signed(data1) < $signed(data2);
        less_unsigned <= data1 < data2;
        a_q           <= data1;
        b_q           <= data2;
        mf_q          <= op[1:0];
        rem_q         <= '0;
        quot_q        <= mag(div_sgn, data1);
        dvs_q         <= mag(div_sgn, data2);
        neg_q         <= div_sgn & (data1[XLEN-1] ^ data2[XLEN-1]);
        neg_r         <= div_sgn & data1[XLEN-1];
        rem_sel       <= op[1];
      end else if (state == S_MUL) begin
        cnt <= cnt + CW'(1);
      end else if (state == S_DIV) begin
        cnt    <= cnt + CW'(1);
        rem_q  <= rem_n;
        quot_q <= quot_n;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (XLEN=32, MUL_LAT=2): scoreboard of expected results built
// from an independent reference model, checked against the DUT per feature.
`timescale 1ns/1ps
module tb_alu_mdu;
  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  localparam logic [4:0] ADD = 5'b00010, SUB = 5'b00110, AND_ = 5'b00000, OR_ = 5'b00111;
  localparam logic [4:0] XOR_ = 5'b00100, SLT = 5'b01010, SLTU = 5'b00011, SLL = 5'b00001;
  localparam logic [4:0] SRL = 5'b00101, SRA = 5'b01101, PASS = 5'b01000, BAD = 5'b01111;
  localparam logic [4:0] MUL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010, MULHU = 5'b10011;
  localparam logic [4:0] DIV = 5'b10100, DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, zero, less, less_unsigned;
  logic [4:0]  op = '0;
  logic [31:0] data1 = '0, data2 = '0, ALU_out;

  alu_mdu #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .data1(data1), .data2(data2), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_out(ALU_out), .zero(zero), .less(less), .less_unsigned(less_unsigned)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; logic z; logic l; logic lu; int lat; } exp_t;
  typedef struct packed { logic [4:0] o; logic [31:0] a; logic [31:0] b; } vec_t;

  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  vec_t alu_tab[13] = '{
    {ADD, 32'd5, 32'd7}, {SUB, 32'd7, 32'd7}, {AND_, 32'hF0F0_1234, 32'h0FF0_FF00},
    {OR_, 32'hF000_0001, 32'h000F_0010}, {XOR_, 32'hAAAA_5555, 32'hFFFF_0000},
    {SLT, 32'hFFFF_FFFF, 32'd1}, {SLTU, 32'hFFFF_FFFF, 32'd1}, {SLL, 32'h0000_0003, 32'h0000_0104},
    {SRL, 32'h8000_0000, 32'd31}, {SRA, 32'h8000_0000, 32'd31}, {PASS, 32'd9, 32'h1234_5000},
    {BAD, 32'd1, 32'd2}, {SRA, 32'h7FFF_FFF0, 32'hFFFF_FFE4}
  };
  vec_t mul_tab[6] = '{
    {MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, {MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    {MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, {MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    {MUL, 32'd12345, 32'd678}, {MULH, 32'h8000_0000, 32'h8000_0000}
  };
  vec_t div_tab[10] = '{
    {DIV, 32'hFFFF_FFF9, 32'd2}, {REM, 32'hFFFF_FFF9, 32'd2}, {DIVU, 32'd100, 32'd7},
    {REMU, 32'd100, 32'd7}, {DIV, 32'h8000_0000, 32'hFFFF_FFFF}, {REM, 32'h8000_0000, 32'hFFFF_FFFF},
    {DIVU, 32'd9, 32'd0}, {REM, 32'd9, 32'd0}, {DIV, 32'd20, 32'hFFFF_FFFB}, {REM, 32'd7, 32'hFFFF_FFFE}
  };

  function automatic exp_t model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sbv, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    e.lat = 1;
    r = '0;
    if (!o[4]) begin
      case (o[3:0])
        4'b0010: r = a + b;
        4'b0110: r = a - b;
        4'b0000: r = a & b;
        4'b0111: r = a | b;
        4'b0100: r = a ^ b;
        4'b1010: r = (sa < sbv) ? 32'd1 : 32'd0;
        4'b0011: r = (ua < ub) ? 32'd1 : 32'd0;
        4'b0001: r = a << b[4:0];
        4'b0101: r = a >> b[4:0];
        4'b1101: r = $signed(a) >>> b[4:0];
        4'b1000: r = b;
        default: r = 32'hdeadbeef;
      endcase
    end else begin
      case (o[2:0])
        3'b000: begin p = sa * sbv; r = p[31:0];  e.lat = MUL_LAT; end
        3'b001: begin p = sa * sbv; r = p[63:32]; e.lat = MUL_LAT; end
        3'b010: begin p = sa * ub;  r = p[63:32]; e.lat = MUL_LAT; end
        3'b011: begin p = ua * ub;  r = p[63:32]; e.lat = MUL_LAT; end
        default: begin
          if (b == 32'd0) r = o[1] ? a : 32'hFFFF_FFFF;
          else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = o[1] ? 32'd0 : a;
          else begin
            e.lat = XLEN + 1;
            case (o[1:0])
              2'b00:   r = 32'(sa / sbv);
              2'b01:   r = 32'(ua / ub);
              2'b10:   r = 32'(sa % sbv);
              default: r = 32'(ua % ub);
            endcase
          end
        end
      endcase
    end
    e.res = r;
    e.z   = (r == 32'd0);
    e.l   = (sa < sbv);
    e.lu  = (ua < ub);
    return e;
  endfunction

  // Drive one op, wait (bounded) for in_ready, let it be accepted, then scramble the inputs.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, output bit ok);
    sb.push_back(model(o, a, b));
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; data1 = a; data2 = b; ok = 1'b0;
    for (int w = 0; w < 60; w++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); data1 = $urandom; data2 = $urandom;
  endtask

  task automatic get_result(output logic [31:0] r, output logic z, output logic l, output logic lu,
                            output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
    end
    r = ALU_out; z = zero; l = less; lu = less_unsigned;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_valid, ALU_out, zero, less, less_unsigned} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b out=%h z=%b l=%b lu=%b expected all zero",
               out_valid, ALU_out, zero, less, less_unsigned);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_alu();
    exp_t e; logic [31:0] r; logic z, l, lu; int lat; bit ok;
    foreach (alu_tab[i]) begin
      issue(alu_tab[i].o, alu_tab[i].a, alu_tab[i].b, ok);
      get_result(r, z, l, lu, lat);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat != e.lat) begin
        n_err++; $display("FAIL alu[%0d]_latency: got %0d accepted=%b expected %0d", i, lat, ok, e.lat);
      end
      n_cmp++;
      if ({r, z, l, lu} !== {e.res, e.z, e.l, e.lu}) begin
        n_err++; $display("FAIL alu[%0d]_result: out=%h z=%b l=%b lu=%b expected %h %b %b %b",
                          i, r, z, l, lu, e.res, e.z, e.l, e.lu);
      end
    end
  endtask

  task automatic test_mul();
    exp_t e; logic [31:0] r; logic z, l, lu; int lat; bit ok;
    foreach (mul_tab[i]) begin
      issue(mul_tab[i].o, mul_tab[i].a, mul_tab[i].b, ok);
      get_result(r, z, l, lu, lat);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat != e.lat) begin
        n_err++; $display("FAIL mul[%0d]_latency: got %0d accepted=%b expected %0d", i, lat, ok, e.lat);
      end
      n_cmp++;
      if ({r, z, l, lu} !== {e.res, e.z, e.l, e.lu}) begin
        n_err++; $display("FAIL mul[%0d]_result: out=%h z=%b l=%b lu=%b expected %h %b %b %b",
                          i, r, z, l, lu, e.res, e.z, e.l, e.lu);
      end
    end
  endtask

  task automatic test_div();
    exp_t e; logic [31:0] r; logic z, l, lu; int lat; bit ok;
    foreach (div_tab[i]) begin
      issue(div_tab[i].o, div_tab[i].a, div_tab[i].b, ok);
      get_result(r, z, l, lu, lat);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat != e.lat) begin
        n_err++; $display("FAIL div[%0d]_latency: got %0d accepted=%b expected %0d", i, lat, ok, e.lat);
      end
      n_cmp++;
      if ({r, z, l, lu} !== {e.res, e.z, e.l, e.lu}) begin
        n_err++; $display("FAIL div[%0d]_result: out=%h z=%b l=%b lu=%b expected %h %b %b %b",
                          i, r, z, l, lu, e.res, e.z, e.l, e.lu);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e; logic [31:0] r; logic z, l, lu; int lat; bit ok;
    issue(ADD, 32'h8000_0000, 32'd1, ok);
    out_ready = 1'b0;
    get_result(r, z, l, lu, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || lat != 1 || r !== e.res) begin
      n_err++; $display("FAIL hold_first: out=%h lat=%0d expected %h lat 1", r, lat, e.res);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, ALU_out, zero, less, less_unsigned} !== {2'b10, e.res, e.z, e.l, e.lu}) begin
        n_err++; $display("FAIL hold[%0d]: valid=%b rdy=%b out=%h z=%b l=%b lu=%b expected 1 0 %h %b %b %b",
                          i, out_valid, in_ready, ALU_out, zero, less, less_unsigned, e.res, e.z, e.l, e.lu);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] a[3] = '{32'd1, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] b[3] = '{32'd2, 32'd4, 32'd1};
    for (int i = 0; i < 3; i++) sb.push_back(model(ADD, a[i], b[i]));
    @(posedge clk); #1;
    in_valid = 1'b1; op = ADD; data1 = a[0]; data2 = b[0];
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_start_ready: got %b expected 1", in_ready); end
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin data1 = a[i]; data2 = b[i]; end
      else in_valid = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({out_valid, ALU_out, zero} !== {1'b1, e.res, e.z}) begin
        n_err++; $display("FAIL b2b[%0d]: valid=%b out=%h z=%b expected 1 %h %b", i, out_valid, ALU_out, zero, e.res, e.z);
      end
      if (i < 3) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b[%0d]_ready: got %b expected 1", i, in_ready); end
      end
    end
  endtask

  task automatic test_flush();
    exp_t e; logic [31:0] r; logic z, l, lu; int lat; bit ok, seen;
    issue(DIV, 32'hFFFF_FFF9, 32'd2, ok);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL flush_idle: valid=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    void'(sb.pop_back());
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL flush_discard: out_valid seen=1 expected 0"); end
    issue(ADD, 32'd1, 32'd1, ok);
    get_result(r, z, l, lu, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || lat != 1 || r !== e.res) begin
      n_err++; $display("FAIL flush_next_add: out=%h lat=%0d expected %h lat 1", r, lat, e.res);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e; logic [31:0] r; logic z, l, lu; int lat; bit ok;
    issue(DIVU, 32'd1000, 32'd3, ok);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, ALU_out, zero} !== {2'b01, 32'd0, 1'b0}) begin
      n_err++; $display("FAIL reset_abort: valid=%b rdy=%b out=%h z=%b expected 0 1 0 0", out_valid, in_ready, ALU_out, zero);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    void'(sb.pop_back());
    issue(ADD, 32'd1, 32'd1, ok);
    get_result(r, z, l, lu, lat);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || lat != 1 || r !== e.res) begin
      n_err++; $display("FAIL reset_next_add: out=%h lat=%0d expected %h lat 1", r, lat, e.res);
    end
  endtask

  task automatic test_random();
    logic [4:0] codes[19] = '{ADD, SUB, AND_, OR_, XOR_, SLT, SLTU, SLL, SRL, SRA, PASS,
                              MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    exp_t e; logic [31:0] r, a, b; logic z, l, lu; int lat; bit ok;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      issue(codes[$urandom_range(0, 18)], a, b, ok);
      get_result(r, z, l, lu, lat);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || lat != e.lat || {r, z, l, lu} !== {e.res, e.z, e.l, e.lu}) begin
        n_err++; $display("FAIL rand[%0d]: a=%h b=%h out=%h z=%b l=%b lu=%b lat=%0d expected %h %b %b %b lat %0d",
                          i, a, b, r, z, l, lu, lat, e.res, e.z, e.l, e.lu, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_hold();
    test_back_to_back();
    test_flush();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
